bcsa_vl_adder: RTL and testbench
================================

# bcsa_vl_adder

Parametrised, pipelined block carry-speculative adder with error detection and optional one-cycle exact correction (variable latency). Successor to the fixed 16-bit combinational speculative adders: width and block size are parameters; results are registered behind a valid/ready handshake. In approximate mode it always returns the speculative sum. In exact mode it spends one extra cycle to return the exact sum whenever speculation fails. A saturating counter tracks speculation failures for error-rate characterisation.

## Interface
- WIDTH, 16, operand width; must be a multiple of BLK
- BLK, 2, speculation block size in bits; BLK = WIDTH makes the adder exact
- CNT_W, 16, width of the mismatch counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a, b  in  WIDTH  unsigned operands
- mode  in  1  0 = approximate, 1 = exact (corrected)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH+1  result, sum[WIDTH] = carry out
- err  out  1  speculation mismatch occurred for this result
- fixed  out  1  result came through the correction cycle
- cnt_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  CNT_W  saturating count of mismatched transactions

## Operation
- Blocks: NB = WIDTH/BLK. Block k covers bits [k*BLK +: BLK].
- Speculative carry into block 0 is 0. Speculative carry into block k>0 (spec_c[k]) is the carry-out of block k-1 computed with carry-in 0, i.e. its group generate.
- Exact carry into block k (exact_c[k]) is the true ripple carry of a+b.
- Speculative sum, block k: low BLK bits of a_k + b_k + spec_c[k]. spec sum[WIDTH] is the carry-out of block NB-1 using spec_c[NB-1].
- Mismatch = OR over k of (spec_c[k] != exact_c[k]).
- Exact sum = a + b, WIDTH+1 bits.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, a, b and mode are latched and the FSM goes to CALC.
  - CALC: if mode_q = 0 or there is no mismatch, load sum = spec sum, err = mismatch, fixed = 0, set out_valid and go to DONE. Otherwise (mode_q = 1 and mismatch) go to FIX.
  - FIX: load sum = exact sum, err = 1, fixed = 1, set out_valid and go to DONE.
  - DONE: outputs held stable while out_ready = 0. On out_ready, out_valid drops. If in_valid is also high that cycle, the new operands are latched and the FSM goes to CALC; otherwise it goes to IDLE.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is combinational and low in CALC and FIX.
- err_cnt increments by 1 on the CALC-exit edge when mismatch = 1, in both modes, and saturates at 2^CNT_W − 1.
- cnt_clr zeroes err_cnt. If cnt_clr coincides with an increment, the clear wins and the result is 0.
- With no mismatch, the speculative sum equals the exact sum in both modes.

## Timing
- Reset (async, any state): state = IDLE, out_valid = 0, sum = 0, err = 0, fixed = 0, err_cnt = 0, operand registers = 0. in_ready = 1 one cycle after reset releases.
- Reset asserted during CALC, FIX or DONE aborts the transaction. No result is emitted and err_cnt is cleared.
- Latency is counted from the accept edge to the edge where out_valid rises:
  - 2 edges for a speculative or clean result.
  - 3 edges for a corrected result.
- Throughput without backpressure: one result per 2 cycles (speculative) or 3 cycles (corrected).
- out_valid, sum, err and fixed change only on clock edges and never change while out_valid = 1 and out_ready = 0.

## Test plan
- WIDTH=16, BLK=2, mode=0, a=0x0001, b=0x0002: sum=0x00003, err=0, fixed=0. out_valid rises 2 edges after accept.
- mode=0, a=0x000F, b=0x0001: sum=0x00000, err=1, fixed=0, err_cnt 0→1.
- Same operands with mode=1: sum=0x00010, err=1, fixed=1. out_valid rises 3 edges after accept; in_ready is low through CALC and FIX.
- mode=0, a=0xFFFF, b=0x0001: sum=0x0FFF0, err=1. The same operands with mode=1 give sum=0x10000, fixed=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands. sum and flags stay stable and in_ready=0. On out_ready=1 the new operands are accepted in the same cycle.
- CNT_W=4: 20 mismatching transactions leave err_cnt=15. cnt_clr together with a mismatching CALC gives err_cnt=0. rst_n pulsed low during FIX gives out_valid=0, sum=0, state IDLE, and no result emitted.

Source files
------------

// File: rtl/bcsa_vl_adder.sv
// Pipelined block carry-speculative adder with mismatch detection and an optional
// one-cycle exact correction (variable latency), behind a valid/ready handshake.
module bcsa_vl_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             err,
  output logic             fixed,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | latched operands evaluated, speculative result or go to FIX
  // FIX   | speculation failed in exact mode, load exact sum
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int NB = WIDTH / BLK;

  state_t           state, state_nx;
  logic             load_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic             mode_q;
  logic [WIDTH:0]   spec_sum, exact_sum;
  logic [NB-1:0]    spec_c, exact_c;
  logic             mismatch;

  assign spec_c[0]  = 1'b0;
  assign exact_c[0] = 1'b0;

  // Speculative carry into block k+1 is block k's group generate; exact carry ripples.
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLK:0] raw0, raw_e;
    assign raw0  = {1'b0, a_q[k*BLK +: BLK]} + {1'b0, b_q[k*BLK +: BLK]};
    assign raw_e = raw0 + (BLK+1)'(exact_c[k]);
    assign exact_sum[k*BLK +: BLK] = raw_e[BLK-1:0];
    if (k == NB-1) begin : g_last
      assign spec_sum[WIDTH:k*BLK] = raw0 + (BLK+1)'(spec_c[k]);
      assign exact_sum[WIDTH]      = raw_e[BLK];
    end else begin : g_mid
      assign spec_sum[k*BLK +: BLK] = raw0[BLK-1:0] + BLK'(spec_c[k]);
      assign spec_c[k+1]            = raw0[BLK];
      assign exact_c[k+1]           = raw_e[BLK];
    end
  end

  assign mismatch = |(spec_c ^ exact_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load_in  = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_in  = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: state_nx = (mode_q && mismatch) ? FIX : DONE;
      FIX:  state_nx = DONE;
      DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load_in  = 1'b1;
            state_nx = CALC;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      err       <= 1'b0;
      fixed     <= 1'b0;
    end else begin
      if (load_in) begin
        a_q    <= a;
        b_q    <= b;
        mode_q <= mode;
      end
      if (state == CALC && !(mode_q && mismatch)) begin
        out_valid <= 1'b1;
        sum       <= spec_sum;
        err       <= mismatch;
        fixed     <= 1'b0;
      end else if (state == FIX) begin
        out_valid <= 1'b1;
        sum       <= exact_sum;
        err       <= 1'b1;
        fixed     <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (cnt_clr)
      err_cnt <= '0;
    else if (state == CALC && mismatch && err_cnt != '1)
      err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bcsa_vl_adder.sv
// Randomised and directed self-checking bench for bcsa_vl_adder (WIDTH=16, BLK=2, CNT_W=4).
module tb_bcsa_vl_adder;
  localparam int WIDTH = 16;
  localparam int BLK   = 2;
  localparam int CNT_W = 4;
  localparam int NB    = WIDTH / BLK;

  logic             clk, rst_n, in_valid, in_ready, mode, out_valid, out_ready;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum;
  logic             err, fixed, cnt_clr;
  logic [CNT_W-1:0] err_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt = 0;

  logic [WIDTH:0] r_sum;
  logic           r_err, r_fixed, r_rdy_bad;
  int             r_lat;

  bcsa_vl_adder #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .err(err), .fixed(fixed), .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: block-wise arithmetic on integers straight from the speculation rules.
  function automatic void model(input longint ma, input longint mb,
                                output longint spec, output longint ex, output bit mis);
    longint mask, ak, bk, pa, pb, sc, ec, s, low;
    mask = (64'd1 << BLK) - 1;
    ex = ma + mb;
    spec = 0;
    mis = 0;
    pa = 0;
    pb = 0;
    for (int k = 0; k < NB; k++) begin
      ak  = (ma >> (k*BLK)) & mask;
      bk  = (mb >> (k*BLK)) & mask;
      sc  = (k == 0) ? 0 : ((pa + pb) >> BLK);
      low = (64'd1 << (k*BLK)) - 1;
      ec  = ((ma & low) + (mb & low)) >> (k*BLK);
      if (sc != ec) mis = 1;
      s = ak + bk + sc;
      spec = spec | ((s & mask) << (k*BLK));
      if (k == NB-1) spec = spec | ((s >> BLK) << WIDTH);
      pa = ak;
      pb = bk;
    end
  endfunction

  task automatic bump(input bit mis);
    if (mis && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  task automatic run_txn(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb2, input logic tm);
    int lat;
    @(negedge clk);
    a = ta; b = tb2; mode = tm; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    r_rdy_bad = 1'b0;
    while (!out_valid && lat < 10) begin
      if (in_ready) r_rdy_bad = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r_lat = lat; r_sum = sum; r_err = err; r_fixed = fixed;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== '0 || err !== 1'b0 || fixed !== 1'b0 || err_cnt !== '0)
      $display("FAIL reset_outputs: out_valid=%b sum=%h err=%b fixed=%b err_cnt=%0d, required 0 0 0 0 0",
               out_valid, sum, err, fixed, err_cnt);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    else pass_cnt++;
    exp_cnt = 0;
  endtask

  task automatic test_directed;
    logic [WIDTH-1:0] ta [5] = '{16'h0001, 16'h000F, 16'h000F, 16'hFFFF, 16'hFFFF};
    logic [WIDTH-1:0] tb2[5] = '{16'h0002, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    logic             tm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [WIDTH:0]   es [5] = '{17'h00003, 17'h00000, 17'h00010, 17'h0FFF0, 17'h10000};
    logic             ee [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic             ef [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int               el [5] = '{2, 2, 3, 2, 3};
    for (int i = 0; i < 5; i++) begin
      run_txn(ta[i], tb2[i], tm[i]);
      bump(ee[i]);
      total_cnt++;
      if (r_sum !== es[i] || r_err !== ee[i] || r_fixed !== ef[i])
        $display("FAIL directed_%0d: sum=%h err=%b fixed=%b, required sum=%h err=%b fixed=%b",
                 i, r_sum, r_err, r_fixed, es[i], ee[i], ef[i]);
      else pass_cnt++;
      total_cnt++;
      if (r_lat != el[i] || r_rdy_bad) $display("FAIL directed_lat_%0d: latency=%0d in_ready_seen=%b, required %0d 0",
                                          i, r_lat, r_rdy_bad, el[i]);
      else pass_cnt++;
      total_cnt++;
      if (err_cnt !== CNT_W'(exp_cnt)) $display("FAIL directed_cnt_%0d: err_cnt=%0d, required %0d", i, err_cnt, exp_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure;
    longint sp1, ex1, sp2, ex2;
    bit m1, m2;
    logic [WIDTH:0] held;
    logic held_e, held_f;
    int w;
    model(64'h1234, 64'h0101, sp1, ex1, m1);
    model(64'h00FF, 64'h0001, sp2, ex2, m2);
    @(negedge clk);
    a = 16'h1234; b = 16'h0101; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    a = 16'h00FF; b = 16'h0001; mode = 1'b1;
    @(posedge clk); @(negedge clk);
    bump(m1);
    total_cnt++;
    if (out_valid !== 1'b1 || sum !== (WIDTH+1)'(sp1))
      $display("FAIL bp_first: out_valid=%b sum=%h, required 1 %h", out_valid, sum, (WIDTH+1)'(sp1));
    else pass_cnt++;
    held = sum; held_e = err; held_f = fixed;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== held || err !== held_e || fixed !== held_f)
        $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b sum=%h err=%b fixed=%b, required 1 0 %h %b %b",
                 i, out_valid, in_ready, sum, err, fixed, held, held_e, held_f);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready);
    else pass_cnt++;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL bp_accept: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    else pass_cnt++;
    w = 0;
    while (!out_valid && w < 10) begin
      @(posedge clk); @(negedge clk);
      w++;
    end
    bump(m2);
    total_cnt++;
    if (sum !== (WIDTH+1)'(m2 ? ex2 : sp2) || err !== m2 || fixed !== m2 || w != 2)
      $display("FAIL bp_second: sum=%h err=%b fixed=%b wait=%0d, required %h %b %b 2",
               sum, err, fixed, w, (WIDTH+1)'(m2 ? ex2 : sp2), m2, m2);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    longint sp, ex;
    bit mis;
    logic [WIDTH-1:0] ra, rb;
    logic rm;
    for (int i = 0; i < 40; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rm = 1'($urandom);
      model(longint'(ra), longint'(rb), sp, ex, mis);
      run_txn(ra, rb, rm);
      bump(mis);
      total_cnt++;
      if (r_sum !== (WIDTH+1)'((rm && mis) ? ex : sp) || r_err !== mis || r_fixed !== (rm && mis) ||
          r_lat != ((rm && mis) ? 3 : 2) || err_cnt !== CNT_W'(exp_cnt))
        $display("FAIL random_%0d a=%h b=%h m=%b: sum=%h err=%b fixed=%b lat=%0d cnt=%0d, required %h %b %b %0d %0d",
                 i, ra, rb, rm, r_sum, r_err, r_fixed, r_lat, err_cnt,
                 (WIDTH+1)'((rm && mis) ? ex : sp), mis, rm && mis, (rm && mis) ? 3 : 2, exp_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clr = 1'b0;
    total_cnt++;
    if (err_cnt !== '0) $display("FAIL cnt_clear_idle: err_cnt=%0d, required 0", err_cnt);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) run_txn(16'h000F, 16'h0001, 1'b0);
    total_cnt++;
    if (err_cnt !== 4'd15) $display("FAIL cnt_saturate: err_cnt=%0d, required 15", err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_clear_collision;
    @(negedge clk);
    a = 16'h000F; b = 16'h0001; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; cnt_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    cnt_clr = 1'b0;
    total_cnt++;
    if (err_cnt !== '0 || out_valid !== 1'b1 || err !== 1'b1)
      $display("FAIL cnt_clr_collision: err_cnt=%0d out_valid=%b err=%b, required 0 1 1", err_cnt, out_valid, err);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_fix;
    bit seen;
    @(negedge clk);
    a = 16'h000F; b = 16'h0001; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || sum !== '0 || err_cnt !== '0 || in_ready !== 1'b1)
      $display("FAIL reset_in_fix: out_valid=%b sum=%h err_cnt=%0d in_ready=%b, required 0 0 0 1",
               out_valid, sum, err_cnt, in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1;
    end
    total_cnt++;
    if (seen || in_ready !== 1'b1) $display("FAIL reset_abort: result_seen=%b in_ready=%b, required 0 1", seen, in_ready);
    else pass_cnt++;
    run_txn(16'h0001, 16'h0002, 1'b0);
    total_cnt++;
    if (r_sum !== 17'h00003 || r_lat != 2) $display("FAIL reset_recover: sum=%h lat=%0d, required 00003 2", r_sum, r_lat);
    else pass_cnt++;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; cnt_clr = 1'b0;
    a = '0; b = '0;
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
    test_saturation;
    test_clear_collision;
    test_reset_fix;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
